// File: rtl/string_reader.sv
// rtl/string_reader.sv - streams null-terminated strings from a 1-cycle-latency ROM over valid/ready
// Optional feature macro: STRING_READER_WRAP_EN (wrap address at end of ROM, cap output at 2**ADDR_W bytes)
module string_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              overrun_d;

`ifdef STRING_READER_WRAP_EN
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      mem_addr_o <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
`ifdef STRING_READER_WRAP_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_addr_o <= addr_d;
      data_o     <= data_d;
      valid_o    <= valid_d;
      overrun_o  <= overrun_d;
`ifdef STRING_READER_WRAP_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = mem_addr_o;
    data_d    = data_o;
    valid_d   = valid_o;
    overrun_d = overrun_o;
`ifdef STRING_READER_WRAP_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          state_d = S_ADDR;
`ifdef STRING_READER_WRAP_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        // The terminator byte is consumed here and never presented downstream.
        if (mem_data_i == '0) begin
          overrun_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          data_d  = mem_data_i;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_i) begin
          valid_d = 1'b0;
`ifdef STRING_READER_WRAP_EN
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            overrun_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            addr_d  = mem_addr_o + 1'b1;
            state_d = S_ADDR;
          end
`else
          if (mem_addr_o == ADDR_LAST) begin
            overrun_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            addr_d  = mem_addr_o + 1'b1;
            state_d = S_ADDR;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_string_reader.sv
// tb/tb_string_reader.sv - scoreboard bench for string_reader
module tb_string_reader;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] start_addr_i = '0;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       busy_o, done_o, overrun_o;

  logic [7:0] rom [16];
  logic [7:0] exp_bytes [$];
  logic       exp_ovr [$];
  int         vr [$];
  int         done_rel, busy_cnt;
  int         total = 0, bad = 0;
  bit         bp = 1'b0;

  string_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .start_addr_i(start_addr_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_i <= rom[mem_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: byte must match the queue head while presented; popped on handshake.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o) begin
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte: got %0h expected none", data_o);
        end else begin
          check("byte", {24'd0, data_o}, {24'd0, exp_bytes[0]});
          if (ready_i) void'(exp_bytes.pop_front());
        end
      end
      if (done_o) begin
        if (exp_ovr.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          check("overrun", {31'd0, overrun_o}, {31'd0, exp_ovr.pop_front()});
        end
      end
    end
  end

  // Backpressure: hold ready low 5 cycles each time a byte appears.
  always begin
    @(negedge clk);
    if (bp && valid_o && !ready_i) begin
      repeat (5) @(posedge clk);
      #1 ready_i = 1'b1;
      @(posedge clk);
      #1 ready_i = 1'b0;
    end
  end

  task automatic run(input logic [3:0] a, input bit inject);
    vr.delete();
    done_rel = -1;
    busy_cnt = 0;
    @(posedge clk); #1 start_i = 1'b1; start_addr_i = a;
    @(posedge clk); #1 start_i = 1'b0;
    for (int rel = 0; rel < 400 && done_rel < 0; rel++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (valid_o) vr.push_back(rel);
      if (done_o) done_rel = rel;
      if (inject && rel == 4) begin
        start_i = 1'b1; start_addr_i = 4'd4;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
    end
    start_i = 1'b0;
    if (done_rel < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done");
    end
    check("bytes_left", exp_bytes.size(), 0);
    check("done_left", exp_ovr.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, {28'd0, mem_addr_o}, 0);
    check({tag, "_data"}, {24'd0, data_o}, 0);
    check({tag, "_valid"}, {31'd0, valid_o}, 0);
    check({tag, "_busy"}, {31'd0, busy_o}, 0);
    check({tag, "_done"}, {31'd0, done_o}, 0);
    check({tag, "_overrun"}, {31'd0, overrun_o}, 0);
  endtask

  initial begin
    rom[0] = 8'h41; rom[1] = 8'h42; rom[2] = 8'h43; rom[3] = 8'h00;
    rom[4] = 8'h45; rom[5] = 8'h46; rom[6] = 8'h47; rom[7] = 8'h48;
    rom[8] = 8'h49; rom[9] = 8'h50; rom[10] = 8'h51; rom[11] = 8'h52;
    rom[12] = 8'h53; rom[13] = 8'h54; rom[14] = 8'h55; rom[15] = 8'h00;

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_ni = 1'b1;

    // 1: "ABC", timing 2 cycles to first byte, 3 cycles per byte
    ready_i = 1'b1;
    exp_bytes = '{8'h41, 8'h42, 8'h43}; exp_ovr.push_back(1'b0);
    run(4'd0, 1'b0);
    check("t1_nbytes", vr.size(), 3);
    if (vr.size() == 3) begin
      check("t1_first", vr[0], 2);
      check("t1_second", vr[1], 5);
      check("t1_third", vr[2], 8);
    end
    check("t1_done_rel", done_rel, 11);

    // 2: 11 bytes from addr 4, 0x50 is data
    exp_bytes = '{8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    exp_ovr.push_back(1'b0);
    run(4'd4, 1'b0);
    check("t2_nbytes", vr.size(), 11);

    // 3: empty string
    exp_ovr.push_back(1'b0);
    run(4'd3, 1'b0);
    check("t3_nbytes", vr.size(), 0);
    check("t3_done_rel", done_rel, 2);
    check("t3_busy", busy_cnt, 3);

    // 4: backpressure with ignored mid-string start
    ready_i = 1'b0; bp = 1'b1;
    exp_bytes = '{8'h41, 8'h42, 8'h43}; exp_ovr.push_back(1'b0);
    run(4'd0, 1'b1);
    bp = 1'b0;
    @(posedge clk); #1 ready_i = 1'b1;

    // 5: unterminated end of ROM
    rom[15] = 8'h5A;
    exp_bytes = '{8'h55, 8'h5A};
`ifdef STRING_READER_WRAP_EN
    exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h43);
    exp_ovr.push_back(1'b0);
`else
    exp_ovr.push_back(1'b1);
`endif
    run(4'd14, 1'b0);
    rom[15] = 8'h00;

    // 6: async reset while in SEND, then clean restart
    ready_i = 1'b0;
    exp_bytes.push_back(8'h45);
    @(posedge clk); #1 start_i = 1'b1; start_addr_i = 4'd4;
    @(posedge clk); #1 start_i = 1'b0;
    for (int i = 0; i < 20 && !valid_o; i++) @(negedge clk);
    if (!valid_o) begin
      total++; bad++;
      $display("FAIL t6_send_timeout: got no valid expected valid");
    end
    #2 rst_ni = 1'b0;
    #1 check_zero("t6_reset");
    exp_bytes.delete();
    exp_ovr.delete();
    @(posedge clk);
    @(negedge clk) rst_ni = 1'b1; ready_i = 1'b1;
    exp_bytes = '{8'h41, 8'h42, 8'h43}; exp_ovr.push_back(1'b0);
    run(4'd0, 1'b0);
    check("t6_nbytes", vr.size(), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/string_reader.md
Name: string_reader

Overview:
Reads null-terminated byte strings from the 1-cycle-latency synchronous ROM and streams them out one byte at a time over a valid/ready interface. A typical sink is a UART transmitter.
- Acts as the address-driving initiator on the ROM read port.
- Is triggered by a start pulse carrying a start address.
- Signals completion with a one-cycle done pulse and an overrun flag.

Parameters:
ADDR_W, 4, width of ROM address bus (ROM depth = 2**ADDR_W)
DATA_W, 8, width of ROM data bus and output byte

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
start_addr_i  in  ADDR_W  first ROM address of string, captured with start_i
mem_addr_o  out  ADDR_W  ROM read address (registered)
mem_data_i  in  DATA_W  ROM read data, valid one cycle after mem_addr_o is sampled by ROM
data_o  out  DATA_W  output byte
valid_o  out  1  data_o valid
ready_i  in  1  sink accepts data_o when valid_o && ready_i at rising edge
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse at end of string
overrun_o  out  1  updated with done_o: 1 = string ended by address limit, not by 0x00; holds until next done_o

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: mem_addr_o, data_o, valid_o, busy_o, done_o, overrun_o. Reset mid-string aborts with no done_o.
- FSM states: IDLE, ADDR, DATA, SEND, DONE.
- IDLE:
  - on start_i: mem_addr_o <= start_addr_i, go ADDR.
  - start_i asserted in any other state is ignored, not queued.
- ADDR: one cycle. mem_addr_o held stable so the ROM registers mem[mem_addr_o] at the closing edge. Go DATA.
- DATA: mem_data_i is valid.
  - If mem_data_i == 0: overrun_o <= 0, go DONE. The terminator is never emitted.
  - Else: data_o <= mem_data_i, valid_o <= 1, go SEND.
- SEND: data_o and valid_o held stable until handshake. On valid_o && ready_i:
  - valid_o <= 0.
  - If mem_addr_o == 2**ADDR_W-1: overrun_o <= 1, go DONE.
  - Else: mem_addr_o <= mem_addr_o+1, go ADDR.
- DONE: done_o = 1 for exactly this cycle, busy_o = 1. Go IDLE. A new start is accepted from the following IDLE cycle.
- Throughput: 3 cycles per byte with ready_i tied high. From start_i sampled to first valid_o: 2 cycles.
- Empty string (first byte 0x00): done_o asserted 3 edges after start_i sampled, zero bytes emitted.
- ready_i high while valid_o low: no effect.
- Address arithmetic is modulo 2**ADDR_W, but without the optional feature no wrap ever occurs (the SEND rule above stops first).

Optional Feature:
Macro STRING_READER_WRAP_EN.
- Defined:
  - In SEND, mem_addr_o wraps from 2**ADDR_W-1 to 0 and reading continues.
  - An internal byte counter (ADDR_W+1 bits, cleared on start) counts handshakes.
  - When the count reaches 2**ADDR_W without a 0x00, go DONE with overrun_o = 1. This caps output at 2**ADDR_W bytes and prevents endless loops on unterminated ROM.
- Not defined: counter absent; end-of-ROM termination as in Behaviour.

Test Plan:
1. ROM "ABC\0EFGHIPQRSTU\0" (0x41,42,43,00,45..49,50..55,00). start_addr_i=0, ready_i=1 -> bytes 0x41,0x42,0x43 then done_o, overrun_o=0. First valid_o 2 cycles after start, 3 cycles between bytes.
2. Same ROM, start_addr_i=4 -> 11 bytes 0x45,46,47,48,49,50,51,52,53,54,55 (0x50 at addr 9 is data, not terminator), then done_o, overrun_o=0.
3. start_addr_i=3 -> no valid_o. done_o pulses 3 edges after start, busy_o high exactly 3 cycles.
4. Backpressure: start_addr_i=0, ready_i low 5 cycles at each byte -> data_o/valid_o stable while stalled, same 3 bytes in order, no byte duplicated or dropped. start_i pulsed mid-string is ignored.
5. ROM with mem[15]=0x5A (no terminator). start_addr_i=14 -> bytes 0x55,0x5A then done_o, overrun_o=1. With STRING_READER_WRAP_EN: continues at addr 0 (0x41,0x42,0x43), stops at 0x00, overrun_o=0.
6. Reset: assert rst_ni low in SEND during string 2 -> all outputs 0 immediately (async). After release, start_addr_i=0 -> clean "ABC" sequence with done_o.
